deser8_1: RTL
=============

# deser8_1

Serial-to-parallel receiver directly downstream of `shiftreg8_1`. It samples the serial `Q` stream one bit per enabled clock, assembles 8-bit words MSB-first or LSB-first to mirror the shifter's direction, and hands completed words to the consumer through a small FIFO with a valid/ready handshake. Words that arrive while the FIFO is full are dropped and flagged.

## Interface
- `WIDTH`, 8: bits per word; also the bit-counter terminal count (WIDTH-1).
- `DEPTH`, 2: output FIFO entries; legal values are 2 and 4.
- `CLK` in 1: clock, 100 MHz; all logic on the rising edge.
- `RST` in 1: reset, asynchronous, active-low (0 = reset).
- `SIN` in 1: serial data, driven from `shiftreg8_1` `Q`.
- `EN` in 1: bit strobe; `SIN` is sampled on rising edges where `EN`=1.
- `DIR` in 1: order; 1 = MSB first (left shift), 0 = LSB first (right shift).
- `SYNC` in 1: frame restart; discards the partial word.
- `DREADY` in 1: consumer ready.
- `DOUT` out WIDTH: FIFO head word.
- `DVALID` out 1: `DOUT` holds a valid word.
- `OVR` out 1: sticky overrun flag.
- `OVR_CLR` in 1: clears `OVR`.
- `BITCNT` out 3: number of bits already captured in the current word (0..WIDTH-1).

## Operation
- Assembly register `sh`, bit counter `cnt`, frame direction `fdir`.
- `EN`=1 with `cnt`=0: latch `fdir`=`DIR`. `DIR` changes mid-word are ignored until the next word.
- Shifting: with `fdir`=1, `sh` <= {sh[WIDTH-2:0], SIN}; with `fdir`=0, `sh` <= {SIN, sh[WIDTH-1:1]}. The bit sampled at `cnt`=0 uses the incoming `DIR` directly.
- `EN`=1 with `cnt`=WIDTH-1: the word is complete. `cnt` wraps to 0 and the assembled word, including the current bit, is pushed to the FIFO.
- `EN`=0: `sh` and `cnt` hold.
- `SYNC`=1: `cnt` <= 0 and the partial word is discarded. If `EN`=1 in the same cycle, that bit is captured as bit 0 of the new word, so `cnt` becomes 1. `SYNC` never touches FIFO contents.
- FIFO is first-word-fall-through:
  - `DVALID` = not empty; `DOUT` = head entry.
  - Pop occurs on `DVALID` & `DREADY`.
- Push while full and no pop in the same cycle: the word is dropped, FIFO contents are unchanged, and `OVR` is set.
- Push while full with a pop in the same cycle: both occur, with no overrun.
- `OVR` is sticky until `OVR_CLR`=1. If a set and `OVR_CLR` occur in the same cycle, the set wins.
- Reset value of every output: `DOUT`=0, `DVALID`=0, `OVR`=0, `BITCNT`=0. Internally, `sh`=0, the FIFO is empty and `fdir`=1.
- `RST` low mid-word or mid-handshake: state clears immediately (asynchronous). Partial words and queued words are lost.

## Timing
- A word completes on the edge that samples its last bit. `DVALID` and `DOUT` update on that same edge and are valid from the following cycle.
- With an empty FIFO, the latency is 1 cycle from the last-bit edge to `DVALID` being visible.
- `DOUT` holds stable while `DVALID`=1 and `DREADY`=0.
- Back-to-back words with `EN` continuously high give one word every WIDTH cycles. A consumer with `DREADY` tied to 1 never causes an overrun.
- `OVR` rises on the edge of the dropped push.
- Release of `RST` is synchronised by the system. The first sample can occur on the first rising edge after release.

## Configuration
- `DESER8_1_OVRCNT_EN` defined:
  - adds output `OVRCNT`, out, 8 bits: a saturating count of dropped words, which stops at 255;
  - `OVRCNT` clears on `RST` and on `OVR_CLR`;
  - a drop and `OVR_CLR` in the same cycle load 1.
- `DESER8_1_OVRCNT_EN` not defined: the port and counter are absent; `OVR` behaviour is identical.

## Test plan
- MSB-first word: `DIR`=1, `EN`=1, `SIN`=1,1,1,1,0,1,0,1, `DREADY`=1.
  - Required response: `DVALID` high for 1 cycle after the 8th edge with `DOUT`=0xF5, and `BITCNT` sequence 0..7 then 0.
- LSB-first word with gaps: `DIR`=0, `SIN`=1,0,1,0,1,1,1,1, with `EN` low for 3 cycles after bit 3.
  - Required response: `DOUT`=0xF5, and `DIR` toggled to 1 after bit 2 has no effect.
- Backpressure and overrun: `DREADY`=0, send 0x11, 0x22, 0x33.
  - `DVALID`=1 with `DOUT`=0x11 stable.
  - `OVR`=1 after the third word.
  - `DREADY`=1 then yields 0x11 then 0x22, then `DVALID`=0.
  - With the macro defined, `OVRCNT`=1.
- Full FIFO with simultaneous pop and push: FIFO holds 0x11 and 0x22, and `DREADY` rises on the last-bit edge of 0xA5.
  - Required response: `OVR` stays 0, and the words delivered are 0x11, 0x22, 0xA5.
- `SYNC` mid-word: send 3 bits, then `SYNC`=1 with `EN`=1 and `SIN`=0, then 7 more bits 1,0,1,0,0,1,0 with `DIR`=1.
  - Required response: `DOUT`=0x52, and nothing from the discarded 3 bits appears.
- Reset mid-operation: `RST` low for 30 ns after 5 bits, with 1 word queued.
  - Immediately: `DVALID`=0, `BITCNT`=0, `OVR`=0.
  - A following clean 8-bit word 0xF5 is received correctly.

Source files
------------

// File: rtl/deser8_1.sv
// rtl/deser8_1.sv - serial-to-parallel word receiver with FWFT output FIFO and sticky overrun flag
// Optional saturating drop counter on OVRCNT when DESER8_1_OVRCNT_EN is defined.
module deser8_1 #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       SIN,
    input  logic                       EN,
    input  logic                       DIR,
    input  logic                       SYNC,
    input  logic                       DREADY,
    input  logic                       OVR_CLR,
    output logic [WIDTH-1:0]           DOUT,
    output logic                       DVALID,
    output logic                       OVR,
`ifdef DESER8_1_OVRCNT_EN
    output logic [7:0]                 OVRCNT,
`endif
    output logic [$clog2(WIDTH)-1:0]   BITCNT
);

    localparam int CW = $clog2(WIDTH);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   OCC_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]   OCC_FULL = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fdir_q, fdir_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW:0]      occ_q, occ_d;
    logic             ovr_q, ovr_d;

    logic [CW-1:0]    cnt_base;
    logic             cur_dir;
    logic [WIDTH-1:0] shifted;
    logic             word_done;
    logic             pop;
    logic             full;
    logic             push;
    logic             drop;

    // SYNC restarts the frame in the same cycle, so the incoming bit is treated as bit 0.
    always_comb begin
        cnt_base  = SYNC ? '0 : cnt_q;
        cur_dir   = (cnt_base == '0) ? DIR : fdir_q;
        shifted   = cur_dir ? {sh_q[WIDTH-2:0], SIN} : {SIN, sh_q[WIDTH-1:1]};
        word_done = EN && (cnt_base == CNT_LAST);

        sh_d   = sh_q;
        cnt_d  = cnt_q;
        fdir_d = fdir_q;
        if (EN) begin
            sh_d   = shifted;
            fdir_d = cur_dir;
            cnt_d  = word_done ? '0 : (cnt_base + CNT_ONE);
        end else if (SYNC) begin
            cnt_d = '0;
        end
    end

    // A completed word may enter a full FIFO only if the head leaves on the same edge.
    always_comb begin
        pop  = (occ_q != '0) && DREADY;
        full = (occ_q == OCC_FULL);
        push = word_done && (!full || pop);
        drop = word_done && full && !pop;

        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        occ_d    = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + OCC_ONE;
        end else if (pop && !push) begin
            occ_d = occ_q - OCC_ONE;
        end

        if (drop) begin
            ovr_d = 1'b1;
        end else if (OVR_CLR) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sh_q     <= '0;
            cnt_q    <= '0;
            fdir_q   <= 1'b1;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            ovr_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            fdir_q   <= fdir_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            ovr_q    <= ovr_d;
            if (push) begin
                mem_q[wr_ptr_q] <= shifted;
            end
        end
    end

`ifdef DESER8_1_OVRCNT_EN
    logic [7:0] ovrcnt_q, ovrcnt_d;

    always_comb begin
        ovrcnt_d = ovrcnt_q;
        if (drop) begin
            if (OVR_CLR) begin
                ovrcnt_d = 8'd1;
            end else if (ovrcnt_q != 8'hFF) begin
                ovrcnt_d = ovrcnt_q + 8'd1;
            end
        end else if (OVR_CLR) begin
            ovrcnt_d = 8'd0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ovrcnt_q <= 8'd0;
        end else begin
            ovrcnt_q <= ovrcnt_d;
        end
    end

    assign OVRCNT = ovrcnt_q;
`endif

    assign DOUT   = mem_q[rd_ptr_q];
    assign DVALID = (occ_q != '0);
    assign OVR    = ovr_q;
    assign BITCNT = cnt_q;

endmodule
